// File: rtl/dma_chan_sched_if.sv
// Descriptor push ports, engine request/completion handshake and interrupt
// handshake of the DMA channel scheduler, bundled for connection as one port.
interface dma_chan_sched_if #(
    parameter int DSCP_WD = 128
);
    logic               c2h_dscp_valid;
    logic [DSCP_WD-1:0] c2h_dscp;
    logic               c2h_dscp_ready;
    logic               h2c_dscp_valid;
    logic [DSCP_WD-1:0] h2c_dscp;
    logic               h2c_dscp_ready;
    logic               eng_req_valid;
    logic               eng_req_ready;
    logic               eng_req_dir;
    logic [DSCP_WD-1:0] eng_req_dscp;
    logic               eng_done;
    logic               eng_err;
    logic               int_req;
    logic               int_ack;

    modport master (
        output c2h_dscp_valid, c2h_dscp, h2c_dscp_valid, h2c_dscp,
               eng_req_ready, eng_done, eng_err, int_ack,
        input  c2h_dscp_ready, h2c_dscp_ready, eng_req_valid, eng_req_dir,
               eng_req_dscp, int_req
    );

    modport slave (
        input  c2h_dscp_valid, c2h_dscp, h2c_dscp_valid, h2c_dscp,
               eng_req_ready, eng_done, eng_err, int_ack,
        output c2h_dscp_ready, h2c_dscp_ready, eng_req_valid, eng_req_dir,
               eng_req_dscp, int_req
    );
endinterface

// File: rtl/dma_chan_sched.sv
// Two-channel (C2H/H2C) DMA descriptor scheduler: per-channel descriptor FIFOs,
// round-robin grant, single outstanding engine transfer, interrupt and error states.
module dma_chan_sched #(
    parameter int DSCP_WD = 128,
    parameter int FIFO_AW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sched_en,
    dma_chan_sched_if.slave bus,
    output logic            busy,
    output logic            err,
    output logic [15:0]     c2h_done_cnt,
    output logic [15:0]     h2c_done_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, INTR, ERR} state_t;

    state_t state_reg, state_next;

    // Channel index 0 is C2H, 1 is H2C; matches the eng_req_dir encoding.
    logic [1:0]         push;
    logic [1:0]         pop;
    logic [1:0]         not_empty;
    logic [1:0]         full;
    logic [DSCP_WD-1:0] push_dscp [2];
    logic [DSCP_WD-1:0] head_dscp [2];

    logic               rdy_en_reg;
    logic               last_grant_reg;
    logic               dir_reg;
    logic [DSCP_WD-1:0] dscp_reg;
    logic [15:0]        c2h_cnt_reg;
    logic [15:0]        h2c_cnt_reg;

    logic               grant_ok;
    logic               grant_dir;
    logic               done_evt;

    assign push_dscp[0] = bus.c2h_dscp;
    assign push_dscp[1] = bus.h2c_dscp;
    assign push[0]      = bus.c2h_dscp_valid & bus.c2h_dscp_ready;
    assign push[1]      = bus.h2c_dscp_valid & bus.h2c_dscp_ready;

    // Ready stays low during reset and rises on the first clock edge after release.
    assign bus.c2h_dscp_ready = rdy_en_reg & ~full[0];
    assign bus.h2c_dscp_ready = rdy_en_reg & ~full[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DSCP_WD-1:0] mem [DEPTH];
            logic [FIFO_AW:0]   wr_ptr_reg;
            logic [FIFO_AW:0]   rd_ptr_reg;

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg[FIFO_AW-1:0]] <= push_dscp[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end

            // Extra pointer MSB separates full (wrapped) from empty.
            assign not_empty[gi] = (wr_ptr_reg != rd_ptr_reg);
            assign full[gi]      = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                                   (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
            assign head_dscp[gi] = mem[rd_ptr_reg[FIFO_AW-1:0]];
        end
    endgenerate

    assign grant_ok  = (state_reg == IDLE) && sched_en && (|not_empty);
    assign grant_dir = (&not_empty) ? ~last_grant_reg : not_empty[1];
    assign pop       = grant_ok ? (grant_dir ? 2'b10 : 2'b01) : 2'b00;
    assign done_evt  = (state_reg == WAIT) && bus.eng_done;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (grant_ok) state_next = ISSUE;
            ISSUE: if (bus.eng_req_ready) state_next = WAIT;
            WAIT: begin
                if (bus.eng_done) begin
                    if (bus.eng_err)  state_next = ERR;
                    else if (dscp_reg[0]) state_next = INTR;
                    else              state_next = IDLE;
                end
            end
            INTR:  if (bus.int_ack) state_next = IDLE;
            ERR:   if (!sched_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rdy_en_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
            dir_reg        <= 1'b0;
            dscp_reg       <= '0;
            c2h_cnt_reg    <= '0;
            h2c_cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            rdy_en_reg <= 1'b1;
            if (grant_ok) begin
                last_grant_reg <= grant_dir;
                dir_reg        <= grant_dir;
                dscp_reg       <= grant_dir ? head_dscp[1] : head_dscp[0];
            end
            if (done_evt) begin
                if (dir_reg) h2c_cnt_reg <= h2c_cnt_reg + 16'd1;
                else         c2h_cnt_reg <= c2h_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.eng_req_valid = (state_reg == ISSUE);
    assign bus.eng_req_dir   = dir_reg;
    assign bus.eng_req_dscp  = dscp_reg;
    assign bus.int_req       = (state_reg == INTR);
    assign busy              = (state_reg != IDLE);
    assign err               = (state_reg == ERR);
    assign c2h_done_cnt      = c2h_cnt_reg;
    assign h2c_done_cnt      = h2c_cnt_reg;
endmodule
